// File: rtl/uart_tx_engine.sv
// UART transmitter: 8N1 or 8E1/8O1 frames, LSB first, with a single-entry hold
// register so one request issued mid-frame is sent back-to-back.
module uart_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       shift, shift_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       hold_data, hold_data_nx;
  logic             hold_valid, hold_valid_nx;
  logic             par, par_nx;
  logic             tx_nx, busy_nx, done_nx, overrun_nx;
  logic             bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Next-state, datapath and registered-output values
  always_comb begin
    state_nx      = state;
    shift_nx      = shift;
    bit_idx_nx    = bit_idx;
    cnt_nx        = cnt;
    hold_data_nx  = hold_data;
    hold_valid_nx = hold_valid;
    par_nx        = par;
    done_nx       = 1'b0;
    overrun_nx    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          state_nx = S_START;
          shift_nx = tx_data;
          par_nx   = (^tx_data) ^ PARITY_ODD;
          cnt_nx   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_nx     = '0;
          bit_idx_nx = 3'd0;
          state_nx   = S_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nx = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = S_STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nx  = '0;
          done_nx = 1'b1;
          if (hold_valid) begin
            state_nx      = S_START;
            shift_nx      = hold_data;
            par_nx        = (^hold_data) ^ PARITY_ODD;
            hold_valid_nx = 1'b0;
          end else if (tx_start) begin
            state_nx = S_START;
            shift_nx = tx_data;
            par_nx   = (^tx_data) ^ PARITY_ODD;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Mid-frame requests go to hold; a hold emptied this cycle can accept one
    if (tx_start && (state != S_IDLE) &&
        !((state == S_STOP) && bit_end && !hold_valid)) begin
      if (!hold_valid_nx) begin
        hold_data_nx  = tx_data;
        hold_valid_nx = 1'b1;
      end else begin
        overrun_nx = 1'b1;
      end
    end

    unique case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = par_nx;
      default:  tx_nx = 1'b1;
    endcase

    busy_nx = (state_nx != S_IDLE) | hold_valid_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      par        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      shift      <= shift_nx;
      bit_idx    <= bit_idx_nx;
      cnt        <= cnt_nx;
      hold_data  <= hold_data_nx;
      hold_valid <= hold_valid_nx;
      par        <= par_nx;
      tx         <= tx_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      overrun    <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a line monitor decodes frames from tx and
// checks them against bytes queued by the directed stimulus.
module tb_uart_tx_engine;

  localparam int unsigned CPB = 4;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start_drv;
  int         sel;

  logic st0, st1, st2;
  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2, ovr0, ovr1, ovr2;
  logic m_tx, m_busy, m_done, m_ovr;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;

  assign st0 = tx_start_drv && (sel == 0);
  assign st1 = tx_start_drv && (sel == 1);
  assign st2 = tx_start_drv && (sel == 2);

  assign m_tx   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : tx2;
  assign m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign m_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign m_ovr  = (sel == 0) ? ovr0  : (sel == 1) ? ovr1  : ovr2;

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_none (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(st0),
    .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0));
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(st1),
    .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1));
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(st2),
    .tx(tx2), .busy(busy2), .done(done2), .overrun(ovr2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Line monitor: sample 1 ns after each rising edge, decode mid-bit
  initial begin
    bit         active = 1'b0;
    int         mcnt = 0;
    int         cyc = 0;
    int         last_end = -100;
    int         flen;
    logic [10:0] bits = '0;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      flen = (sel == 0) ? int'(10 * CPB) : int'(11 * CPB);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (m_done) done_cnt++;
        if (m_ovr)  ovr_cnt++;
        if (active) begin
          if ((mcnt % CPB) == CPB / 2) bits[mcnt / CPB] = m_tx;
          if (mcnt == flen) begin
            active   = 1'b0;
            last_end = cyc;
            check("done_at_frame_end", 32'(m_done), 32'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("start_bit", 32'(bits[0]), 32'd0);
              check("data_byte", 32'(bits[8:1]), 32'(e.data));
              if (sel == 0) begin
                check("stop_bit", 32'(bits[9]), 32'd1);
              end else begin
                check("parity_bit", 32'(bits[9]), 32'(e.par));
                check("stop_bit", 32'(bits[10]), 32'd1);
              end
            end
          end else begin
            mcnt++;
          end
        end
        if (!active && (m_tx == 1'b0)) begin
          active = 1'b1;
          mcnt   = 1;
          bits   = '0;
          if (exp_q.size() != 0 && exp_q[0].b2b)
            check("back_to_back_gap", 32'(cyc - last_end), 32'd0);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic p, input bit b);
    exp_t e;
    e.data = d;
    e.par  = p;
    e.b2b  = b;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    tx_data      = d;
    tx_start_drv = 1'b1;
    @(negedge clk);
    tx_start_drv = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 400), 32'd1);
    wait_neg(3);
  endtask

  task automatic new_test(input int s);
    sel      = s;
    done_cnt = 0;
    ovr_cnt  = 0;
    @(negedge clk);
  endtask

  initial begin
    int busy_low;
    rst_n        = 1'b1;
    tx_data      = 8'h00;
    tx_start_drv = 1'b0;
    sel          = 0;
    #2 rst_n = 1'b0;
    wait_neg(3);
    check("reset_tx", 32'(m_tx), 32'd1);
    check("reset_busy", 32'(m_busy), 32'd0);
    check("reset_done", 32'(m_done), 32'd0);
    check("reset_overrun", 32'(m_ovr), 32'd0);
    rst_n = 1'b1;
    wait_neg(2);

    // Single frame, no parity
    new_test(0);
    push(8'hA5, 1'b0, 1'b0);
    send(8'hA5);
    check("busy_after_start", 32'(m_busy), 32'd1);
    wait_idle("single");
    check("single_done_count", 32'(done_cnt), 32'd1);

    // Parity variants
    new_test(1);
    push(8'hA5, 1'b0, 1'b0);
    send(8'hA5);
    wait_idle("even_a5");
    push(8'h01, 1'b1, 1'b0);
    send(8'h01);
    wait_idle("even_01");
    check("even_done_count", 32'(done_cnt), 32'd2);
    new_test(2);
    push(8'h01, 1'b0, 1'b0);
    send(8'h01);
    wait_idle("odd_01");

    // Queued send: busy held through both contiguous frames
    new_test(0);
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    busy_low     = 0;
    tx_data      = 8'h11;
    tx_start_drv = 1'b1;
    @(negedge clk);
    tx_start_drv = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (!m_busy) busy_low++;
      if (i == 10) begin
        tx_data      = 8'h22;
        tx_start_drv = 1'b1;
      end else begin
        tx_start_drv = 1'b0;
      end
      @(negedge clk);
    end
    check("queued_busy_low_cycles", 32'(busy_low), 32'd0);
    check("queued_busy_drop", 32'(m_busy), 32'd0);
    wait_idle("queued");
    check("queued_done_count", 32'(done_cnt), 32'd2);

    // Overrun: third request dropped
    new_test(0);
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    send(8'h11);
    wait_neg(9);
    send(8'h22);
    check("no_overrun_on_hold", 32'(m_ovr), 32'd0);
    wait_neg(8);
    send(8'h33);
    check("overrun_pulse", 32'(m_ovr), 32'd1);
    wait_idle("overrun");
    check("overrun_count", 32'(ovr_cnt), 32'd1);
    check("overrun_done_count", 32'(done_cnt), 32'd2);

    // Request coincident with the end of stop while hold is full
    new_test(0);
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    push(8'h44, 1'b0, 1'b1);
    send(8'h11);
    wait_neg(9);
    send(8'h22);
    wait_neg(29);
    send(8'h44);
    wait_idle("coincident");
    check("coincident_overrun_count", 32'(ovr_cnt), 32'd0);
    check("coincident_done_count", 32'(done_cnt), 32'd3);

    // Reset during data bits, then a clean frame
    new_test(0);
    push(8'h77, 1'b0, 1'b0);
    send(8'h77);
    wait_neg(15);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", 32'(m_tx), 32'd1);
    check("midreset_busy", 32'(m_busy), 32'd0);
    exp_q.delete();
    wait_neg(2);
    rst_n = 1'b1;
    new_test(0);
    push(8'h5A, 1'b0, 1'b0);
    send(8'h5A);
    wait_idle("post_reset");
    check("post_reset_done_count", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
